lsu_mem_stage: RTL

//  Load/store unit directly downstream of the ALU: takes the effective address (alu_res) plus
//  op info from EX and runs a multi-cycle req/gnt/rvalid transaction to the data memory port.

---
 rtl/lsu_mem_stage_if.sv | 44 ++++
 rtl/lsu_mem_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage_if.sv
// Bundle of the EX request, data-memory port and writeback response of the LSU.
// slave is the LSU view; master is the surrounding EX/memory/writeback view.
interface lsu_mem_stage_if #(
   parameter int unsigned XLEN = 64
);
   localparam int unsigned NBYTES = XLEN / 8;

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [XLEN-1:0]   req_addr;
   logic [XLEN-1:0]   req_wdata;

   logic              mem_req;
   logic              mem_we;
   logic [XLEN-1:0]   mem_addr;
   logic [XLEN-1:0]   mem_wdata;
   logic [NBYTES-1:0] mem_wmask;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [XLEN-1:0]   mem_rdata;

   logic              resp_valid;
   logic [XLEN-1:0]   resp_rdata;
   logic              resp_err;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output req_ready,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      output resp_valid, resp_rdata, resp_err
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  req_ready,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      input  resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/lsu_mem_stage.sv
// LSU memory stage: accepts one load/store from EX, runs a req/gnt/rvalid
// transaction on the 8-lane data port and returns one registered response.
module lsu_mem_stage #(
   parameter int unsigned XLEN = 64
) (
   input logic            clk,
   input logic            rst_n,
   lsu_mem_stage_if.slave bus
);
   localparam int unsigned NBYTES = XLEN / 8;
   localparam int unsigned OFF_W  = 3;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

   state_e            state_q, state_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic              req_ready_q, req_ready_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   logic [NBYTES-1:0] mem_wmask_q, mem_wmask_d;
   logic              resp_valid_q, resp_valid_d;
   logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;

   logic [OFF_W-1:0]  req_off_c;

   assign req_off_c = bus.req_addr[OFF_W-1:0];

   function automatic logic is_misaligned(input logic [1:0] size, input logic [OFF_W-1:0] off);
      case (size)
         2'd1:    is_misaligned = off[0];
         2'd2:    is_misaligned = |off[1:0];
         2'd3:    is_misaligned = |off;
         default: is_misaligned = 1'b0;
      endcase
   endfunction

   function automatic logic [NBYTES-1:0] byte_mask(input logic [1:0] size, input logic [OFF_W-1:0] off);
      logic [NBYTES-1:0] base;
      case (size)
         2'd0:    base = NBYTES'(8'h01);
         2'd1:    base = NBYTES'(8'h03);
         2'd2:    base = NBYTES'(8'h0F);
         default: base = NBYTES'(8'hFF);
      endcase
      byte_mask = base << off;
   endfunction

   // Pick the addressed lane out of the aligned word and extend to XLEN.
   function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] rdata,
                                                    input logic [OFF_W-1:0] off,
                                                    input logic [1:0] size,
                                                    input logic uns);
      logic [XLEN-1:0] sh;
      sh = rdata >> {off, 3'b000};
      case (size)
         2'd0:    extend_load = {{(XLEN-8){~uns & sh[7]}}, sh[7:0]};
         2'd1:    extend_load = {{(XLEN-16){~uns & sh[15]}}, sh[15:0]};
         2'd2:    extend_load = {{(XLEN-32){~uns & sh[31]}}, sh[31:0]};
         default: extend_load = sh;
      endcase
   endfunction

   // Next-state and registered-output computation.
   always_comb begin
      state_d      = state_q;
      off_d        = off_q;
      size_d       = size_q;
      uns_d        = uns_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wmask_d  = mem_wmask_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               off_d  = req_off_c;
               size_d = bus.req_size;
               uns_d  = bus.req_unsigned;
               if (is_misaligned(bus.req_size, req_off_c)) begin
                  // Memory is left untouched; the error goes straight to writeback.
                  state_d      = RESP;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else begin
                  state_d     = ADDR;
                  resp_err_d  = 1'b0;
                  mem_we_d    = bus.req_we;
                  mem_addr_d  = {bus.req_addr[XLEN-1:OFF_W], OFF_W'(0)};
                  mem_wdata_d = bus.req_we ? (bus.req_wdata << {req_off_c, 3'b000}) : '0;
                  mem_wmask_d = bus.req_we ? byte_mask(bus.req_size, req_off_c) : '0;
               end
            end
         end
         ADDR: begin
            if (bus.mem_gnt) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (bus.mem_rvalid) begin
               state_d      = RESP;
               resp_rdata_d = mem_we_q ? '0 : extend_load(bus.mem_rdata, off_q, size_q, uns_q);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      req_ready_d  = (state_d == IDLE);
      mem_req_d    = (state_d == ADDR);
      resp_valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         off_q        <= '0;
         size_q       <= '0;
         uns_q        <= 1'b0;
         req_ready_q  <= 1'b1;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wmask_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         off_q        <= off_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         req_ready_q  <= req_ready_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wmask_q  <= mem_wmask_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.mem_wmask  = mem_wmask_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
endmodule
